// File: rtl/sigma_delta_pkg.sv
// Shared constants and helpers for the sigma-delta ADC harness and scheduler.
package sigma_delta_pkg;

    localparam int unsigned CIC_STAGES_DEF = 2;
    localparam int unsigned OSR_DEF        = 1024;

    // CIC output growth: 2 sign/guard bits plus log2(OSR) per integrator stage
    function automatic int unsigned calc_adc_bitlen(input int unsigned cic_stages,
                                                    input int unsigned osr);
        return 2 + cic_stages * $clog2(osr);
    endfunction

    localparam int unsigned ADC_BITLEN_DEF = calc_adc_bitlen(CIC_STAGES_DEF, OSR_DEF);

endpackage

// File: rtl/sigma_delta_adc_scheduler_if.sv
// Scheduled sample stream: data tagged with channel index, valid/ready handshake.
interface sigma_delta_adc_scheduler_if #(
    parameter int unsigned ADC_BITLEN = 22,
    parameter int unsigned CH_W       = 2
) ();

    logic [ADC_BITLEN-1:0] out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sigma_delta_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module sigma_delta_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    logic [IW-1:0] cand;

    // Scan N positions starting at ptr, wrapping modulo N
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any_c && req[cand]) begin
                any_c         = 1'b1;
                idx_c         = cand;
                grant_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc_scheduler.sv
// Merges NUM_CH decimated ADC streams onto one tagged valid/ready stream,
// discarding CIC start-up samples and flagging per-channel overruns.
module sigma_delta_adc_scheduler
    import sigma_delta_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ADC_BITLEN     = ADC_BITLEN_DEF,
    parameter int unsigned SETTLE_SAMPLES = CIC_STAGES_DEF,
    parameter int unsigned CH_W           = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_CH*ADC_BITLEN-1:0] ch_sample,
    input  logic [NUM_CH-1:0]            ch_valid,
    sigma_delta_adc_scheduler_if.master  out_if,
    output logic [NUM_CH-1:0]            settled,
    output logic [NUM_CH-1:0]            overrun,
    input  logic                         overrun_clr
);

    localparam int unsigned CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_SAMPLES);

    logic [CNT_W-1:0]      cnt_q  [NUM_CH];
    logic [CNT_W-1:0]      cnt_d  [NUM_CH];
    logic [ADC_BITLEN-1:0] hold_q [NUM_CH];
    logic [ADC_BITLEN-1:0] hold_d [NUM_CH];
    logic [NUM_CH-1:0]     pend_q;
    logic [NUM_CH-1:0]     pend_d;
    logic [NUM_CH-1:0]     ovr_set_c;
    logic [NUM_CH-1:0]     overrun_d;
    logic [NUM_CH-1:0]     settled_d;
    logic [CH_W-1:0]       ptr_q;
    logic [CH_W-1:0]       ptr_d;

    logic [ADC_BITLEN-1:0] out_data_d;
    logic [CH_W-1:0]       out_ch_d;
    logic                  out_valid_d;

    logic                  slot_free_c;
    logic [NUM_CH-1:0]     arb_req_c;
    logic [NUM_CH-1:0]     arb_grant_c;
    logic [CH_W-1:0]       arb_idx_c;
    logic                  arb_any_c;
    logic [NUM_CH-1:0]     gnt_c;
    logic                  gnt_any_c;

    // Grants only while running and when the output slot can take a sample
    always_comb begin
        slot_free_c = !out_if.out_valid || out_if.out_ready;
        arb_req_c   = pend_q & {NUM_CH{enable}};
        gnt_c       = arb_grant_c & {NUM_CH{slot_free_c}};
        gnt_any_c   = arb_any_c && slot_free_c;
    end

    sigma_delta_rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .req     (arb_req_c),
        .ptr     (ptr_q),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c),
        .any_c   (arb_any_c)
    );

    // Next-state for settle counters, holding registers, flags, pointer and output slot
    always_comb begin
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        ovr_set_c   = '0;
        settled_d   = '0;
        ptr_d       = ptr_q;
        out_data_d  = out_if.out_data;
        out_ch_d    = out_if.out_ch;
        out_valid_d = out_if.out_valid;

        for (int i = 0; i < NUM_CH; i++) begin
            if (!enable) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else begin
                if (ch_valid[i] && (cnt_q[i] < SETTLE_CNT)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (gnt_c[i]) begin
                    pend_d[i] = 1'b0;
                end
                // A strobe only lands once the channel was already settled
                if (ch_valid[i] && (cnt_q[i] == SETTLE_CNT)) begin
                    if (!pend_q[i] || gnt_c[i]) begin
                        pend_d[i] = 1'b1;
                        hold_d[i] = ch_sample[i*ADC_BITLEN +: ADC_BITLEN];
                    end else begin
                        ovr_set_c[i] = 1'b1;
                    end
                end
            end
            settled_d[i] = enable && (cnt_d[i] == SETTLE_CNT);
        end

        overrun_d = ovr_set_c | (overrun & ~{NUM_CH{overrun_clr}});

        if (gnt_any_c) begin
            out_data_d  = hold_q[arb_idx_c];
            out_ch_d    = arb_idx_c;
            out_valid_d = 1'b1;
            ptr_d       = (arb_idx_c == CH_W'(NUM_CH - 1)) ? '0 : arb_idx_c + CH_W'(1);
        end else if (out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q            <= '{default: '0};
            hold_q           <= '{default: '0};
            pend_q           <= '0;
            ptr_q            <= '0;
            settled          <= '0;
            overrun          <= '0;
            out_if.out_data  <= '0;
            out_if.out_ch    <= '0;
            out_if.out_valid <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            hold_q           <= hold_d;
            pend_q           <= pend_d;
            ptr_q            <= ptr_d;
            settled          <= settled_d;
            overrun          <= overrun_d;
            out_if.out_data  <= out_data_d;
            out_if.out_ch    <= out_ch_d;
            out_if.out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc_scheduler.sv
// Directed bench for the sample scheduler with a cycle-level reference model.
module tb_sigma_delta_adc_scheduler;

    localparam int NCH    = 4;
    localparam int W      = 22;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH*W-1:0]  ch_sample;
    logic [NCH-1:0]    ch_valid;
    logic              out_ready;
    logic [NCH-1:0]    settled;
    logic [NCH-1:0]    overrun;
    logic              overrun_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    typedef struct {
        int ch;
        int data;
        int cyc;
    } ent_t;
    ent_t log_q[$];

    sigma_delta_adc_scheduler_if #(.ADC_BITLEN(W), .CH_W(2)) out_if ();
    assign out_if.out_ready = out_ready;

    sigma_delta_adc_scheduler #(
        .NUM_CH         (NCH),
        .ADC_BITLEN     (W),
        .SETTLE_SAMPLES (SETTLE),
        .CH_W           (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_sample   (ch_sample),
        .ch_valid    (ch_valid),
        .out_if      (out_if),
        .settled     (settled),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel state held as plain integers
    int          m_cnt  [NCH];
    bit          m_pend [NCH];
    int          m_hold [NCH];
    bit          m_ov   [NCH];
    bit          m_set  [NCH];
    int          m_ptr;
    bit          m_valid;
    int          m_data;
    int          m_ch;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update and handshake log, both on the active edge
    always @(posedge clk) begin
        int  g;
        bit  free;
        bit  setbit [NCH];
        cyc++;
        if (rst && out_if.out_valid && out_ready)
            log_q.push_back('{int'(out_if.out_ch), int'(out_if.out_data), cyc});
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_pend[c] = 0; m_hold[c] = 0; m_ov[c] = 0; m_set[c] = 0;
            end
            m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0;
        end else begin
            free = !m_valid || out_ready;
            g = -1;
            if (enable && free) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
                end
            end
            if (g >= 0) begin
                m_data  = m_hold[g];
                m_ch    = g;
                m_valid = 1;
                m_pend[g] = 0;
                m_ptr   = (g + 1) % NCH;
            end else if (out_ready) begin
                m_valid = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                setbit[c] = 0;
                if (!enable) begin
                    m_cnt[c] = 0;
                    m_pend[c] = 0;
                end else if (ch_valid[c]) begin
                    if (m_cnt[c] < SETTLE) m_cnt[c]++;
                    else if (!m_pend[c]) begin
                        m_pend[c] = 1;
                        m_hold[c] = int'(ch_sample[c*W +: W]);
                    end else setbit[c] = 1;
                end
                if (setbit[c]) m_ov[c] = 1;
                else if (overrun_clr) m_ov[c] = 0;
                m_set[c] = enable && (m_cnt[c] == SETTLE);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int exp_set, exp_ov;
        if (started) begin
            exp_set = 0; exp_ov = 0;
            for (int c = 0; c < NCH; c++) begin
                exp_set |= int'(m_set[c]) << c;
                exp_ov  |= int'(m_ov[c]) << c;
            end
            chk("model_out_valid", int'(out_if.out_valid), int'(m_valid));
            if (m_valid) begin
                chk("model_out_data", int'(out_if.out_data), m_data);
                chk("model_out_ch", int'(out_if.out_ch), m_ch);
            end
            chk("model_settled", int'(settled), exp_set);
            chk("model_overrun", int'(overrun), exp_ov);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe1(input int c, input int v);
        ch_sample[c*W +: W] = W'(v);
        ch_valid = '0;
        ch_valid[c] = 1'b1;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic strobe_mask(input logic [NCH-1:0] m, input int base);
        for (int c = 0; c < NCH; c++) ch_sample[c*W +: W] = W'(base + c * 'h100);
        ch_valid = m;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic expect_out(input string name, input int c, input int d, output int t);
        if (log_q.size() == 0) begin
            checks++;
            errors++;
            t = -1;
            $display("FAIL %s act=no_output exp=ch%0d/%0h", name, c, d);
        end else begin
            ent_t e;
            e = log_q.pop_front();
            chk({name, "_ch"}, e.ch, c);
            chk({name, "_data"}, e.data, d);
            t = e.cyc;
        end
    endtask

    task automatic expect_none(input string name);
        chk(name, log_q.size(), 0);
        log_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3;
        rst = 1'b0; enable = 1'b0; ch_valid = '0; ch_sample = '0;
        out_ready = 1'b1; overrun_clr = 1'b0;
        tick(2);
        started = 1'b1;
        chk("reset_out_valid", int'(out_if.out_valid), 0);
        chk("reset_out_data", int'(out_if.out_data), 0);
        chk("reset_out_ch", int'(out_if.out_ch), 0);
        chk("reset_settled", int'(settled), 0);
        chk("reset_overrun", int'(overrun), 0);
        rst = 1'b1; enable = 1'b1;
        tick(1);

        // Start-up discard on channel 0
        strobe1(0, 'h10);
        chk("discard_settled_1st", int'(settled[0]), 0);
        strobe1(0, 'h11);
        chk("discard_settled_2nd", int'(settled[0]), 1);
        strobe1(0, 'h12);
        tick(3);
        expect_out("discard_emit", 0, 'h12, t0);
        expect_none("discard_only_one");

        // Settle the remaining channels, then a ch3 sample wraps ptr to 0
        strobe_mask(4'b1110, 'h900);
        strobe_mask(4'b1110, 'h900);
        chk("all_settled", int'(settled), 'hF);
        expect_none("settle_no_emit");
        strobe1(3, 'h333);
        chk("latency_1cyc", int'(out_if.out_valid), 0);
        tick(1);
        chk("latency_2cyc_valid", int'(out_if.out_valid), 1);
        chk("latency_2cyc_data", int'(out_if.out_data), 'h333);
        tick(2);
        expect_out("ch3_emit", 3, 'h333, t0);

        // Fairness: simultaneous strobes emitted in ptr order, back to back
        strobe_mask(4'hF, 0);
        tick(6);
        expect_out("fair_a0", 0, 'h000, t0);
        expect_out("fair_a1", 1, 'h100, t1);
        expect_out("fair_a2", 2, 'h200, t2);
        expect_out("fair_a3", 3, 'h300, t3);
        chk("fair_consec", t3 - t0, 3);
        strobe_mask(4'hF, 1);
        tick(6);
        expect_out("fair_b0", 0, 'h001, t0);
        expect_out("fair_b1", 1, 'h101, t1);
        expect_out("fair_b2", 2, 'h201, t2);
        expect_out("fair_b3", 3, 'h301, t3);

        // Overrun under a stalled output
        out_ready = 1'b0;
        strobe1(0, 'h77);
        tick(1);
        strobe1(1, 'hA);
        strobe1(1, 'hB);
        chk("ovr_flag", int'(overrun), 'b0010);
        chk("ovr_slot_stable", int'(out_if.out_data), 'h77);
        out_ready = 1'b1;
        tick(3);
        expect_out("ovr_slot", 0, 'h77, t0);
        expect_out("ovr_held", 1, 'hA, t0);
        expect_none("ovr_dropped");
        chk("ovr_sticky", int'(overrun), 'b0010);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Same-cycle grant and capture on channel 2
        out_ready = 1'b0;
        strobe1(0, 'h1);
        tick(1);
        strobe1(2, 'h5);
        out_ready = 1'b1;
        strobe1(2, 'h6);
        tick(3);
        expect_out("same_slot", 0, 'h1, t0);
        expect_out("same_old", 2, 'h5, t0);
        expect_out("same_new", 2, 'h6, t0);
        chk("same_no_ovr", int'(overrun), 0);

        // enable drop flushes pending but lets the slot finish
        out_ready = 1'b0;
        strobe1(1, 'h21);
        tick(1);
        strobe_mask(4'b1001, 'h30);
        enable = 1'b0;
        tick(2);
        chk("en_settled_low", int'(settled), 0);
        chk("en_slot_valid", int'(out_if.out_valid), 1);
        chk("en_slot_data", int'(out_if.out_data), 'h21);
        out_ready = 1'b1;
        tick(3);
        expect_out("en_slot_done", 1, 'h21, t0);
        expect_none("en_pending_lost");
        enable = 1'b1;
        strobe1(0, 'h40);
        chk("reen_discard", int'(settled[0]), 0);
        strobe1(0, 'h41);
        strobe1(0, 'h42);
        tick(3);
        expect_out("reen_emit", 0, 'h42, t0);
        expect_none("reen_only_one");

        // Synchronous reset in the middle of a stall
        out_ready = 1'b0;
        strobe1(2, 'h50);
        tick(1);
        strobe1(3, 'h51);
        overrun_clr = 1'b0;
        rst = 1'b0;
        tick(1);
        chk("rst_out_valid", int'(out_if.out_valid), 0);
        chk("rst_out_data", int'(out_if.out_data), 0);
        chk("rst_out_ch", int'(out_if.out_ch), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(4);
        expect_none("rst_pending_lost");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigma_delta_adc_scheduler.md
# sigma_delta_adc_scheduler

Multi-channel sample scheduler placed after NUM_CH independent sigma-delta ADC harness instances (modulator, CIC decimator and DC block). It discards each channel's CIC start-up transient, buffers one decimated sample per channel, and merges all channels round-robin onto a single valid/ready output stream tagged with the channel index. It also reports per-channel overruns when a downstream stall causes samples to be lost.

## Interface
- NUM_CH, 4: number of ADC channels, ≥2
- ADC_BITLEN, 22: sample width, equal to the harness ADC_BITLEN
- SETTLE_SAMPLES, 2: decimated samples discarded per channel after start, equal to CIC_STAGES; 0 disables discard
- CH_W, $clog2(NUM_CH): derived width of the channel index
- clk  in  1  bit clock
- rst  in  1  reset; synchronous, active-low
- enable  in  1  run control; low flushes all channel state
- ch_sample  in  NUM_CH×ADC_BITLEN  per-channel decimated sample
- ch_valid  in  NUM_CH  single-cycle strobe per channel, qualifying ch_sample
- out_data  out  ADC_BITLEN  scheduled sample
- out_ch  out  CH_W  channel index of out_data
- out_valid  out  1  output handshake valid
- out_ready  in  1  output handshake ready
- settled  out  NUM_CH  channel has passed its discard window
- overrun  out  NUM_CH  sticky flag: a sample was dropped on this channel
- overrun_clr  in  1  clears all overrun bits

## Operation
- Per-channel settle counter, 0..SETTLE_SAMPLES:
  - Increments on ch_valid while enable=1 and the counter is below SETTLE_SAMPLES.
  - Samples that arrive while the counter is below SETTLE_SAMPLES are discarded; the strobe that increments the counter is itself discarded.
  - settled[i] = (count == SETTLE_SAMPLES).
- Per-channel holding register plus pending flag. When ch_valid[i], enable and settled[i] are all set:
  - pending clear, or pending being granted this cycle: capture the sample and set pending.
  - Otherwise: drop the new sample, keep the held one, set overrun[i].
- Arbitration is round-robin over the pending flags:
  - Search starts at ptr. The grant goes to the first pending channel.
  - After a grant, ptr = granted index + 1, wrapping at NUM_CH.
  - A grant occurs only when the output slot is empty or is being accepted this cycle (out_valid & out_ready).
- The output slot is a registered out_data/out_ch/out_valid triple.
  - A grant loads the slot and clears that channel's pending flag on the same edge.
  - out_data and out_ch stay stable while out_valid=1 and out_ready=0.
- enable=0:
  - Clears all pending flags and settle counters; ch_valid is ignored.
  - The output slot is not flushed; it completes its handshake normally.
  - ptr is held.
- overrun_clr has priority below a same-cycle set, so a set wins.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, settled=0, overrun=0, ptr=0, all pending=0, all counters=0.
- Latency with the slot free and no contention: ch_valid sampled at edge N, pending at N, out_valid=1 after edge N+1. That is 2 cycles.
- Back-to-back throughput is 1 sample per cycle while out_ready=1.
- Simultaneous ch_valid on all channels: channels are emitted on consecutive cycles in ptr order, with no loss.
- Capture and grant on the same channel in the same cycle: the old sample goes out, the new one is captured, and no overrun is flagged.
- Reset mid-handshake: out_valid drops at the reset edge and the pending sample is lost without an overrun flag.
- SETTLE_SAMPLES=0: settled=1 from the first cycle after reset with enable=1.

## Structure
- Shared package sigma_delta_pkg holds the default ADC_BITLEN/CIC_STAGES constants and a function computing ADC_BITLEN = 2 + CIC_STAGES·clog2(OSR), for reuse by the harness.
- Sub-module sigma_delta_rr_arbiter (parameter N) provides the combinational request→one-hot grant from ptr, plus the grant index. The scheduler owns ptr and all registers.

## Test plan
- Start-up discard: SETTLE_SAMPLES=2, one channel, samples 0x10,0x11,0x12 → only 0x12 is emitted. settled rises after the second strobe.
- Fairness: NUM_CH=4, all strobe the same cycle with values ch·0x100 → out_ch sequence 0,1,2,3 on 4 consecutive cycles. The next burst starts at 0.
- Overrun: out_ready=0, ch1 strobes 0xA then 0xB → 0xA is held, overrun[1]=1. Then raise out_ready → 0xA out, and overrun_clr clears the flag.
- Same-cycle capture/grant: ch2 pending 0x5, slot accepting, new ch2 strobe 0x6 → 0x5 out, then 0x6 out, overrun stays 0.
- enable drop: pending on ch0/ch3 with the slot full, then enable=0 → the slot sample completes, pending is lost, settled goes to 0. Re-enable → discard restarts.
- Reset: rst low for 1 cycle mid-stall → all outputs at reset values on the next cycle.
